spi_cmd_master: RTL

- SPI mode-0 master that issues one command frame: command byte, 0-5 parameter bytes, 0-3 readback bytes.
- It is the initiator side of the FPGA command-slave protocol (opcodes bram_poke=1, bram_peek=2, dbus_read=3, …). Used for bench-driving the slave and for FPGA-to-FPGA control links.
- Host logic pulses start with a frame descriptor. The block drives CS/SCK/MOSI, captures MISO during readback bytes, then pulses done.

---
 rtl/spi_cmd_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_master.sv
// SPI mode-0 master that sends one command frame: cmd byte, 0-5 parameter bytes, 0-3 readback bytes.
// Define SPI_BYTE_GAP_EN to insert BYTE_GAP idle cycles between bytes while CS stays low.
module spi_cmd_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_GUARD = 8,
  parameter int unsigned BYTE_GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [39:0] params,
  input  logic [2:0]  n_params,
  input  logic [1:0]  n_read,
  output logic        busy,
  output logic        done,
  output logic [23:0] rdata,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        CS
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_GAP,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_phase;
  logic [2:0]         r_bit;
  logic [3:0]         r_byte;
  logic [3:0]         r_last;
  logic [2:0]         r_np;
  logic [39:0]        r_params;
  logic [7:0]         r_tx;
  logic [7:0]         r_rx;
  logic               r_miso_s1;
  logic               r_miso_s2;
  logic               r_cs;
  logic               r_sck;
  logic               r_busy;
  logic               r_done;
  logic [23:0]        r_rdata;

  logic [2:0]         w_np_clamped;
  logic [3:0]         w_next_byte;
  logic               w_next_is_param;
  logic [7:0]         w_next_tx;
  logic [7:0]         w_rx_byte;
  logic               w_is_read;
  logic [1:0]         w_rd_idx;
  logic               w_div_end;
  logic               w_guard_end;
  logic               w_gap_end;

  assign w_np_clamped    = (n_params > 3'd5) ? 3'd5 : n_params;
  assign w_next_byte     = r_byte + 4'd1;
  assign w_next_is_param = (w_next_byte <= {1'b0, r_np});
  assign w_next_tx       = w_next_is_param ? r_params[7:0] : 8'h00;
  assign w_rx_byte       = {r_rx[6:0], r_miso_s2};
  assign w_is_read       = (r_byte > {1'b0, r_np});
  assign w_rd_idx        = 2'(r_byte - 4'd1 - {1'b0, r_np});
  assign w_div_end       = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_guard_end     = (r_cnt == CNT_W'(CS_GUARD - 1));
  assign w_gap_end       = (r_cnt == CNT_W'(BYTE_GAP - 1));

  // Frame sequencer; DONE also accepts a new start so CS stays high for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_bit     <= 3'd7;
      r_byte    <= 4'd0;
      r_last    <= 4'd0;
      r_np      <= 3'd0;
      r_params  <= 40'd0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
      r_cs      <= 1'b1;
      r_sck     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= 24'd0;
    end else begin
      r_miso_s1 <= MISO;
      r_miso_s2 <= r_miso_s1;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (start && !r_busy) begin
            r_state  <= S_CS_SETUP;
            r_busy   <= 1'b1;
            r_cs     <= 1'b0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_bit    <= 3'd7;
            r_byte   <= 4'd0;
            r_np     <= w_np_clamped;
            r_last   <= 4'(w_np_clamped) + 4'(n_read);
            r_params <= params;
            r_tx     <= cmd;
            r_rdata  <= 24'd0;
          end
        end
        S_CS_SETUP: begin
          if (w_guard_end) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (!w_div_end) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (!r_phase) begin
            r_cnt   <= '0;
            r_sck   <= 1'b1;
            r_phase <= 1'b1;
          end else begin
            r_cnt   <= '0;
            r_sck   <= 1'b0;
            r_phase <= 1'b0;
            r_rx    <= w_rx_byte;
            if (r_bit != 3'd0) begin
              r_bit <= r_bit - 3'd1;
              r_tx  <= {r_tx[6:0], 1'b0};
            end else begin
              r_bit <= 3'd7;
              if (w_is_read) begin
                case (w_rd_idx)
                  2'd0:    r_rdata[7:0]   <= w_rx_byte;
                  2'd1:    r_rdata[15:8]  <= w_rx_byte;
                  default: r_rdata[23:16] <= w_rx_byte;
                endcase
              end
              if (r_byte == r_last) begin
                r_state <= S_CS_HOLD;
                r_tx    <= 8'd0;
              end else begin
                r_byte <= w_next_byte;
                r_tx   <= w_next_tx;
                if (w_next_is_param) begin
                  r_params <= {8'h00, r_params[39:8]};
                end
`ifdef SPI_BYTE_GAP_EN
                r_state <= S_GAP;
`endif
              end
            end
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CS_HOLD: begin
          if (w_guard_end) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_cs    <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign SCK   = r_sck;
  assign MOSI  = r_tx[7];
  assign CS    = r_cs;

endmodule
